// File: rtl/pcie_scrambler_ctrl_if.sv
// Valid/ready bundle between the link-layer TX mux, the scrambler sequencer
// and the scrambler. slave = sequencer view, master = the surrounding logic.
interface pcie_scrambler_ctrl_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_eop;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_scramble;

  modport slave (
    input  in_valid, in_data, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_scramble
  );

  modport master (
    output in_valid, in_data, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_scramble
  );
endinterface

// File: rtl/pcie_scrambler_ctrl.sv
// Scrambler sequencer: registers link-layer words towards the PHY TX
// scrambler, drives LFSR advance/reseed and the per-word scramble flag, and
// inserts SKP ordered sets at packet boundaries once the interval expires.
// Optional build macro PCIE_SCR_STATS_EN adds skp_count / word_count outputs.
module pcie_scrambler_ctrl #(
  parameter int                    DATA_WIDTH   = 128,
  parameter int                    SKP_INTERVAL = 1180,
  parameter int                    SKP_WORDS    = 1,
  parameter logic [DATA_WIDTH-1:0] SKP_WORD     = {(DATA_WIDTH/8){8'h1C}}
)(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         link_up,
  input  logic                         scr_disable,
  pcie_scrambler_ctrl_if.slave         bus,
  output logic                         lfsr_adv,
  output logic                         lfsr_reset,
  output logic                         skp_pending,
  output logic [1:0]                   state
`ifdef PCIE_SCR_STATS_EN
  ,
  output logic [15:0]                  skp_count,
  output logic [31:0]                  word_count
`endif
);

  localparam int CW = $clog2(SKP_INTERVAL);
  localparam int SW = (SKP_WORDS > 1) ? $clog2(SKP_WORDS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(SKP_INTERVAL - 1);
  localparam logic [SW-1:0] SKP_LAST = SW'(SKP_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DATA = 2'b01,
    S_SKP  = 2'b10
  } st_e;

  st_e                   st_q, st_d;
  logic [CW-1:0]         cnt_q;
  logic [SW-1:0]         skpn_q;
  logic                  in_pkt_q;
  logic                  blk_q;
  logic                  rs_q;
  logic                  ov_q;
  logic                  os_q;
  logic [DATA_WIDTH-1:0] od_q;

  logic cnt_sat, ins_block, out_free, accept, xfer, boundary, skp_last, go_skp;

  // Handshake and scheduling terms shared by every register below.
  // A pending SKP outside a packet closes the input immediately so no new
  // packet can start ahead of the ordered set.
  assign cnt_sat   = (cnt_q == CNT_MAX);
  assign ins_block = blk_q | (cnt_sat & ~in_pkt_q);
  assign out_free  = ~ov_q | bus.out_ready;
  assign accept    = bus.in_valid & bus.in_ready;
  assign xfer      = ov_q & bus.out_ready;
  assign boundary  = ~in_pkt_q | (accept & bus.in_eop);
  assign skp_last  = (st_q == S_SKP) & xfer & (skpn_q == SKP_LAST);
  assign go_skp    = (st_q == S_DATA) & ins_block & out_free;

  assign bus.in_ready     = (st_q == S_DATA) & ~ins_block & out_free;
  assign bus.out_valid    = ov_q;
  assign bus.out_data     = od_q;
  assign bus.out_scramble = os_q;
  assign lfsr_adv         = xfer & os_q;
  assign lfsr_reset       = rs_q;
  assign skp_pending      = cnt_sat;
  assign state            = st_q;

  // Next-state logic; loss of L0 wins from any state.
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:  if (link_up)  st_d = S_DATA;
      S_DATA:  if (go_skp)   st_d = S_SKP;
      S_SKP:   if (skp_last) st_d = S_DATA;
      default:               st_d = S_IDLE;
    endcase
    if (!link_up) st_d = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st_q <= S_IDLE;
    else          st_q <= st_d;
  end

  // SKP interval counter: counts DATA cycles, parks at the limit until the
  // ordered set has gone out (frozen there during SKP backpressure).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  cnt_q <= '0;
    else if (!link_up || skp_last || st_q == S_IDLE) cnt_q <= '0;
    else if (st_q == S_DATA && !cnt_sat)           cnt_q <= cnt_q + CW'(1);
  end

  // Packet tracking and input block once a SKP has found its boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_pkt_q <= 1'b0;
      blk_q    <= 1'b0;
    end else begin
      if (!link_up)    in_pkt_q <= 1'b0;
      else if (accept) in_pkt_q <= ~bus.in_eop;
      if (!link_up || st_q != S_DATA) blk_q <= 1'b0;
      else if (cnt_sat && boundary)   blk_q <= 1'b1;
    end
  end

  // Index of the SKP word currently on the output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       skpn_q <= '0;
    else if (!link_up || st_q != S_SKP) skpn_q <= '0;
    else if (xfer)                      skpn_q <= skpn_q + SW'(1);
  end

  // Output register: data words carry the scramble flag sampled at
  // acceptance; SKP words are never scrambled. Link loss drops the word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ov_q <= 1'b0;
      os_q <= 1'b0;
      od_q <= '0;
    end else if (!link_up) begin
      ov_q <= 1'b0;
    end else if (go_skp) begin
      ov_q <= 1'b1;
      os_q <= 1'b0;
      od_q <= SKP_WORD;
    end else if (accept) begin
      ov_q <= 1'b1;
      os_q <= ~scr_disable;
      od_q <= bus.in_data;
    end else if (xfer && (st_q != S_SKP || skp_last)) begin
      ov_q <= 1'b0;
    end
  end

  // LFSR reseed: held through IDLE, one pulse after the final SKP word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rs_q <= 1'b1;
    else          rs_q <= (st_d == S_IDLE) | skp_last;
  end

`ifdef PCIE_SCR_STATS_EN
  // Wrapping statistics; nothing moves in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skp_count  <= '0;
      word_count <= '0;
    end else if (st_q != S_IDLE) begin
      if (skp_last) skp_count  <= skp_count + 16'd1;
      if (lfsr_adv) word_count <= word_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcie_scrambler_ctrl.sv
// Bench for pcie_scrambler_ctrl: directed scenarios plus a random phase,
// checked every cycle against a cycle-level behavioural model.
module tb_pcie_scrambler_ctrl;
  localparam int W      = 128;
  localparam int INTV   = 16;
  localparam int NSKP   = 1;
  localparam logic [W-1:0] SKPW = {16{8'h1C}};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       link_up = 1'b0;
  logic       scr_disable = 1'b0;
  logic       lfsr_adv, lfsr_reset, skp_pending;
  logic [1:0] state;
`ifdef PCIE_SCR_STATS_EN
  logic [15:0] skp_count;
  logic [31:0] word_count;
`endif

  pcie_scrambler_ctrl_if #(.DATA_WIDTH(W)) bus();

  pcie_scrambler_ctrl #(
    .DATA_WIDTH(W), .SKP_INTERVAL(INTV), .SKP_WORDS(NSKP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .link_up(link_up), .scr_disable(scr_disable),
    .bus(bus), .lfsr_adv(lfsr_adv), .lfsr_reset(lfsr_reset),
    .skp_pending(skp_pending), .state(state)
`ifdef PCIE_SCR_STATS_EN
    , .skp_count(skp_count), .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_st: 0 idle, 1 data, 2 skp. m_age counts DATA cycles since link-up or
  // the last SKP; a SKP is due once it reaches INTV-1.
  int          m_st = 0, m_age = 0, m_skp_left = 0;
  bit          m_inpkt = 0, m_hold = 0, m_ov = 0, m_os = 0, m_rs = 1;
  logic [W-1:0] m_od = '0;

  typedef struct packed { bit pend, blocked, in_ready, acc, xfer, adv; } mc_t;

  function automatic mc_t mc();
    mc_t r;
    r.pend     = (m_age >= INTV - 1);
    r.blocked  = m_hold || (r.pend && !m_inpkt);
    r.in_ready = (m_st == 1) && !r.blocked && (!m_ov || bus.out_ready);
    r.acc      = bus.in_valid && r.in_ready;
    r.xfer     = m_ov && bus.out_ready;
    r.adv      = r.xfer && m_os;
    return r;
  endfunction

  mc_t mcv;
  bit  bnd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st = 0; m_age = 0; m_inpkt = 0; m_hold = 0; m_ov = 0; m_os = 0;
      m_od = '0; m_rs = 1; m_skp_left = 0;
    end else begin
      mcv = mc();
      if (!link_up) begin
        m_st = 0; m_ov = 0; m_inpkt = 0; m_age = 0; m_hold = 0; m_rs = 1; m_skp_left = 0;
      end else if (m_st == 0) begin
        m_st = 1; m_rs = 0;
      end else if (m_st == 1) begin
        m_rs = 0;
        bnd = !m_inpkt || (mcv.acc && bus.in_eop);
        if (mcv.pend && bnd) m_hold = 1;
        if (mcv.blocked && (!m_ov || bus.out_ready)) begin
          m_st = 2; m_ov = 1; m_od = SKPW; m_os = 0; m_skp_left = NSKP; m_hold = 0;
        end else if (mcv.acc) begin
          m_ov = 1; m_od = bus.in_data; m_os = !scr_disable;
        end else if (mcv.xfer) begin
          m_ov = 0;
        end
        if (mcv.acc) m_inpkt = !bus.in_eop;
        m_age++;
      end else begin
        m_rs = 0;
        if (mcv.xfer) begin
          m_skp_left--;
          if (m_skp_left == 0) begin
            m_st = 1; m_ov = 0; m_age = 0; m_rs = 1;
          end
        end
      end
    end
  end

  // ---------------- compare process + transfer log ----------------
  typedef struct { logic [W-1:0] d; logic s; } xf_t;
  xf_t log_q[$];
  int  adv_cnt = 0, rs_cnt = 0;
  mc_t cv;

  always @(negedge clk) begin
    if (cmp_en) begin
      cv = mc();
      chk("state",       W'(state),         W'(m_st[1:0]));
      chk("in_ready",    W'(bus.in_ready),  W'(cv.in_ready));
      chk("out_valid",   W'(bus.out_valid), W'(m_ov));
      chk("lfsr_adv",    W'(lfsr_adv),      W'(cv.adv));
      chk("lfsr_reset",  W'(lfsr_reset),    W'(m_rs));
      chk("skp_pending", W'(skp_pending),   W'(cv.pend));
      if (m_ov) begin
        chk("out_data",     bus.out_data,         m_od);
        chk("out_scramble", W'(bus.out_scramble), W'(m_os));
      end
    end
    if (bus.out_valid && bus.out_ready) log_q.push_back('{bus.out_data, bus.out_scramble});
    if (lfsr_adv)   adv_cnt++;
    if (lfsr_reset) rs_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Presents one word and waits for its acceptance; leaves in_valid high.
  task automatic send(input logic [W-1:0] d, input bit eop);
    bit acc = 0;
    int n = 0;
    bus.in_valid = 1; bus.in_data = d; bus.in_eop = eop;
    while (!acc && n < 100) begin
      @(negedge clk); acc = bus.in_ready; n++;
      @(posedge clk); #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: word %0h not accepted in %0d cycles", d, n);
    end
  endtask

  task automatic wait_state(input logic [1:0] s);
    int n = 0;
    while (state !== s && n < 200) begin cyc(); n++; end
    chk("wait_state", W'(state), W'(s));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    xf_t f[$];
    bus.in_valid = 0; bus.in_data = '0; bus.in_eop = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk); #1;
    cmp_en = 1;

    // reset values
    @(negedge clk);
    chk("rst_state",   W'(state), '0);
    chk("rst_in_ready", W'(bus.in_ready), '0);
    chk("rst_out_valid", W'(bus.out_valid), '0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_scramble", W'(bus.out_scramble), '0);
    chk("rst_lfsr_adv", W'(lfsr_adv), '0);
    chk("rst_lfsr_reset", W'(lfsr_reset), W'(1));
    chk("rst_skp_pending", W'(skp_pending), '0);
    @(posedge clk); #1; reset_n = 1;
    cyc();

    // link up: IDLE -> DATA after one clock
    link_up = 1;
    @(negedge clk);
    chk("up_idle_state", W'(state), '0);
    chk("up_idle_reset", W'(lfsr_reset), W'(1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("up_data_state", W'(state), W'(1));
    chk("up_data_reset", W'(lfsr_reset), '0);
    chk("up_in_ready", W'(bus.in_ready), W'(1));
    @(posedge clk); #1;

    // stream 1..8
    log_q.delete(); adv_cnt = 0;
    for (int i = 1; i <= 8; i++) send(W'(i), i == 8);
    bus.in_valid = 0;
    repeat (2) cyc();
    chk("stream_len", W'(log_q.size()), W'(8));
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      chk("stream_data", log_q[i].d, W'(i + 1));
      chk("stream_scr", W'(log_q[i].s), W'(1));
    end
    chk("stream_adv", W'(adv_cnt), W'(8));

    // idle SKP, then a 10-word packet spanning the next expiry
    wait_state(2'b10);
    wait_state(2'b01);
    repeat (8) cyc();
    log_q.delete(); rs_cnt = 0;
    for (int i = 1; i <= 10; i++) send(W'(32'h100 + i), i == 10);
    bus.in_valid = 0;
    repeat (8) cyc();
    chk("skp_len", W'(log_q.size()), W'(11));
    if (log_q.size() >= 11) begin
      chk("skp_eop_word", log_q[9].d, W'(32'h10A));
      chk("skp_word", log_q[10].d, SKPW);
      chk("skp_noscr", W'(log_q[10].s), '0);
    end
    chk("skp_reseed", W'(rs_cnt), W'(1));

    // backpressure + scr_disable on words 3..4 of 6
    log_q.delete();
    send(W'(201), 0); send(W'(202), 0);
    scr_disable = 1;
    send(W'(203), 0);
    bus.out_ready = 0; bus.in_data = W'(204);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", W'(bus.in_ready), '0);
      chk("bp_adv", W'(lfsr_adv), '0);
      chk("bp_data", bus.out_data, W'(203));
      @(posedge clk); #1;
    end
    bus.out_ready = 1;
    send(W'(204), 0);
    scr_disable = 0;
    send(W'(205), 0); send(W'(206), 1);
    bus.in_valid = 0;
    repeat (6) cyc();
    foreach (log_q[i]) if (log_q[i].d !== SKPW) f.push_back(log_q[i]);
    chk("bp_len", W'(f.size()), W'(6));
    for (int i = 0; i < 6 && i < f.size(); i++) begin
      chk("bp_word", f[i].d, W'(201 + i));
      chk("bp_scr", W'(f[i].s), W'((i == 2 || i == 3) ? 0 : 1));
    end

    // link drop mid-packet with a word held on the output
    send(W'(301), 0); send(W'(302), 0);
    bus.in_valid = 0; bus.out_ready = 0;
    cyc();
    link_up = 0;
    cyc();
    @(negedge clk);
    chk("drop_state", W'(state), '0);
    chk("drop_out_valid", W'(bus.out_valid), '0);
    chk("drop_reset", W'(lfsr_reset), W'(1));
    chk("drop_pending", W'(skp_pending), '0);
    @(posedge clk); #1;
    link_up = 1; bus.out_ready = 1;

    // random phase with one async reset in the middle
    for (int c = 0; c < 2000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
      bus.in_eop    = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) scr_disable = ~scr_disable;
      if (!link_up) link_up = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 299) == 0) link_up = 0;
      if (c == 1000) begin
        #2 reset_n = 0;
        @(negedge clk);
        chk("arst_state", W'(state), '0);
        chk("arst_out_valid", W'(bus.out_valid), '0);
        chk("arst_reset", W'(lfsr_reset), W'(1));
        chk("arst_pending", W'(skp_pending), '0);
        @(posedge clk); #1;
        reset_n = 1;
      end
      cyc();
    end
    bus.in_valid = 0;
    k = 0;
    repeat (3) cyc();
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
